cyc_ctl_gen: RTL and testbench
==============================

# cyc_ctl_gen

Parametrised cycle-control sequencer for the ND-120 CPU board. It is the configurable successor of the fixed-encoding PAL cycle state counter. Each CPU cycle is classified on its first tick: short, fast (hit), normal, slow, break or long. The block then counts out the class's programmed length, stalls at defined wait points for bus grant and WAIT1/WAIT2, and produces a one-tick TERM_n that latches the next microinstruction. It adds programmable cycle lengths, a wider state counter, a one-shot DLY1 stretch and a stall watchdog, none of which the PAL version has.

## Interface
Parameters:
- CC_W, 4, tick-counter width; every LEN_* ≤ 2**CC_W.
- LEN_SHORT, 2, ticks in a SHORT cycle.
- LEN_FAST, 3, ticks in a HIT/SHORT cycle when the DLY0/CSDELAY0 stretch applies.
- LEN_NORM, 4, ticks in a normal memory cycle.
- LEN_SLOW, 8, ticks in a SLOW cycle.
- LEN_BRK, 8, ticks in a BRK cycle.
- LEN_LONG, 9, ticks in a UART/LCS/RWCS cycle.
- WAIT_POS, 2, tick index of the bus/WAIT1 stall point; WAIT2 stalls at WAIT_POS+1.
- TO_W, 6, watchdog counter width; timeout fires after 2**TO_W−1 consecutive stall ticks.

Ports:
- CK in 1: system clock (OSC). One clock; all state changes on the rising edge.
- RESET in 1: asynchronous, active-high reset.
- SHORT_n, SLOW_n, BRK_n in 1 each: cycle-type requests, active low.
- LONG in 1: UART/LCS/RWCS cycle request.
- HIT in 1: cache hit.
- DLY0_n, DLY1_n in 1 each: delay requests from the delay PALs, active low.
- CSDELAY0 in 1: microcode delay bit.
- WAIT1, WAIT2 in 1 each: memory wait requests.
- CGNTCACT_n in 1: another master holds the bus, active low.
- TERM_n out 1: last tick of the current cycle, active low.
- CC_n out CC_W: inverted tick index.
- CLS out 3: latched cycle class, debug only.
- TOUT out 1: one-tick watchdog pulse.

## Operation
- Tick 0 classification uses fixed priority, first match wins:
  - LONG → LONG.
  - BRK_n=0 → BRK.
  - SLOW_n=0 → SLOW.
  - SHORT_n=0 & DLY0_n=1 & CSDELAY0=0 → SHORT.
  - HIT=1 or SHORT_n=0 → FAST.
  - Otherwise NORM.
- The class and its length L are held in registers until TERM. Inputs after tick 0 do not change the class.
- Class encoding in CLS: SHORT=0, FAST=1, NORM=2, SLOW=3, BRK=4, LONG=5.
- DLY1 stretch: if the class is FAST and DLY1_n=0 at tick 1, L is incremented by 1. This happens at most once per cycle.
- Stall A applies at cnt=WAIT_POS for classes NORM, SLOW and LONG. The counter holds while (WAIT1 & BRK_n) | ~CGNTCACT_n.
- Stall B applies at cnt=WAIT_POS+1 for the same classes. The counter holds while WAIT2 & BRK_n.
- BRK cycles never stall on WAIT1/WAIT2, but they do stall A on bus grant. SHORT and FAST cycles never stall.
- Watchdog: counts consecutive stall ticks and clears whenever the counter advances. On reaching all-ones, the stall is released, TOUT pulses for one tick and the cycle completes normally.

## Timing
- Reset values: cnt=0, CC_n=all ones, TERM_n=1, TOUT=0, CLS=NORM, watchdog=0.
- The first tick after reset is a tick 0.
- Tick counter behaviour: cnt advances by 1 per un-stalled tick, covering 0..L−1. TERM_n is 0 exactly during the tick where cnt=L−1. The next tick is cnt=0 of a new cycle.
- TERM_n, CC_n, CLS and TOUT are all registered; there is no combinational path from input to output.
- Stall-point sampling: inputs sampled at the edge ending the stall-point tick decide whether cnt holds.
- Minimum cycle is LEN_SHORT ticks, with TERM_n low on the second tick when LEN_SHORT=2.
- Simultaneous events:
  - Watchdog expiry together with a stall release: a single advance, and TOUT still pulses.
  - BRK together with any other request at tick 0: BRK wins unless LONG is also requested.
- Reset asserted mid-cycle: all outputs return to reset values immediately (asynchronous). Counting restarts at tick 0 on the first edge after release.
- Legal parameters: LEN_* ≥ 2, WAIT_POS+1 < LEN_NORM, and WAIT_POS+1 < L for every stalling class. Elaboration must fail otherwise.

## Structure
- Shared package cyc_ctl_pkg holds:
  - the cycle-class enum (3 bits);
  - default LEN_* constants;
  - the priority function class_sel().
- Sub-module cyc_ctl_wdog contains the TO_W stall counter with TOUT generation.
- Counter, class register and TERM register stay in the top module.

## Test plan
- Reset, then SHORT_n=0 held with all else idle → TERM_n low every 2nd tick, CC_n alternating 1111/1110, CLS=0.
- HIT=1, DLY1_n=0 at tick 1 → FAST cycle of 4 ticks, TERM_n low at cnt=3.
- NORM cycle with WAIT1=1 for 5 ticks at cnt=2 → cycle lasts 9 ticks; same stimulus with BRK_n=0 → 8-tick BRK cycle with no WAIT1 hold.
- CGNTCACT_n=0 held forever during a NORM cycle → cnt sticks at 2 for 63 ticks, TOUT pulses once, TERM_n low 1 tick later (cnt=3).
- LONG=1 and BRK_n=0 together at tick 0 → CLS=5, 9-tick cycle.
- RESET pulsed at cnt=5 of a SLOW cycle → CC_n=1111 and TERM_n=1 immediately; a new classification occurs on the first edge after release.

Source files
------------

// File: rtl/cyc_ctl_pkg.sv
// -----------------------------------------------------------------------------
// cyc_ctl_pkg
// Shared definitions for the ND-120 cycle-control sequencer:
//   - cls_e      : 3-bit cycle-class encoding (also driven out on CLS)
//   - DEF_*      : default parameter values for cyc_ctl_gen
//   - class_sel(): fixed-priority tick-0 cycle classification
// -----------------------------------------------------------------------------
package cyc_ctl_pkg;

    typedef enum logic [2:0] {
        CLS_SHORT = 3'd0,
        CLS_FAST  = 3'd1,
        CLS_NORM  = 3'd2,
        CLS_SLOW  = 3'd3,
        CLS_BRK   = 3'd4,
        CLS_LONG  = 3'd5
    } cls_e;

    localparam int DEF_CC_W      = 4;
    localparam int DEF_LEN_SHORT = 2;
    localparam int DEF_LEN_FAST  = 3;
    localparam int DEF_LEN_NORM  = 4;
    localparam int DEF_LEN_SLOW  = 8;
    localparam int DEF_LEN_BRK   = 8;
    localparam int DEF_LEN_LONG  = 9;
    localparam int DEF_WAIT_POS  = 2;
    localparam int DEF_TO_W      = 6;

    // First match wins. LONG outranks BRK; a SHORT request only yields a
    // true SHORT cycle when neither delay stretch (DLY0_n low or CSDELAY0)
    // is asking for extra time, otherwise it falls into the FAST length.
    function automatic cls_e class_sel(
        input logic long_req,
        input logic brk_n,
        input logic slow_n,
        input logic short_n,
        input logic dly0_n,
        input logic csdelay0,
        input logic hit
    );
        if (long_req)
            return CLS_LONG;
        else if (!brk_n)
            return CLS_BRK;
        else if (!slow_n)
            return CLS_SLOW;
        else if (!short_n && dly0_n && !csdelay0)
            return CLS_SHORT;
        else if (hit || !short_n)
            return CLS_FAST;
        else
            return CLS_NORM;
    endfunction

endpackage

// File: rtl/cyc_ctl_wdog.sv
// -----------------------------------------------------------------------------
// cyc_ctl_wdog
// Stall watchdog. Counts consecutive ticks in which the sequencer is held at a
// stall point. A stall point may be occupied for at most 2**TO_W-1 ticks: the
// hold is dropped on the last of them, and TOUT is high during that final
// stalled tick.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   stall_req : a stall condition is present at the current stall point
//   hold      : combinational, counter must hold this tick
//   tout      : registered one-tick timeout pulse
// -----------------------------------------------------------------------------
module cyc_ctl_wdog #(
    parameter int TO_W = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic stall_req,
    output logic hold,
    output logic tout
);

    // wd_q counts hold edges already taken at this stall point, so the
    // current tick is stall tick number wd_q+1. Tick number 2**TO_W-1 is
    // the last one allowed, i.e. wd_q == all-ones minus one.
    localparam logic [TO_W-1:0] WD_LAST = {{(TO_W-1){1'b1}}, 1'b0};
    localparam logic [TO_W-1:0] WD_PRE  = WD_LAST - 1'b1;

    logic [TO_W-1:0] wd_q, wd_d;
    logic            tout_q, tout_d;

    always_comb begin
        hold   = stall_req && (wd_q != WD_LAST);
        wd_d   = hold ? wd_q + 1'b1 : '0;
        tout_d = hold && (wd_q == WD_PRE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q   <= '0;
            tout_q <= 1'b0;
        end else begin
            wd_q   <= wd_d;
            tout_q <= tout_d;
        end
    end

    assign tout = tout_q;

endmodule

// File: rtl/cyc_ctl_gen.sv
// -----------------------------------------------------------------------------
// cyc_ctl_gen
// Cycle-control sequencer for the ND-120 CPU board. Classifies each CPU cycle
// on its first tick, counts out the programmed length for that class, stalls
// at the bus/WAIT1 and WAIT2 points, and emits a one-tick active-low TERM_n
// on the last tick of the cycle.
// Ports:
//   CK, RESET         : clock, asynchronous active-high reset
//   SHORT_n, SLOW_n,
//   BRK_n, LONG, HIT  : cycle-type requests (tick 0 only)
//   DLY0_n, CSDELAY0  : select FAST instead of SHORT for SHORT requests
//   DLY1_n            : one-tick stretch of FAST cycles, sampled at tick 1
//   WAIT1, WAIT2      : memory wait requests at the stall points
//   CGNTCACT_n        : bus held by another master (stall A)
//   TERM_n            : low on the last tick of the cycle
//   CC_n              : inverted tick index
//   CLS               : class of the current cycle (valid from tick 1)
//   TOUT              : stall watchdog pulse
// All outputs are registered.
// -----------------------------------------------------------------------------
module cyc_ctl_gen
    import cyc_ctl_pkg::*;
#(
    parameter int CC_W      = DEF_CC_W,
    parameter int LEN_SHORT = DEF_LEN_SHORT,
    parameter int LEN_FAST  = DEF_LEN_FAST,
    parameter int LEN_NORM  = DEF_LEN_NORM,
    parameter int LEN_SLOW  = DEF_LEN_SLOW,
    parameter int LEN_BRK   = DEF_LEN_BRK,
    parameter int LEN_LONG  = DEF_LEN_LONG,
    parameter int WAIT_POS  = DEF_WAIT_POS,
    parameter int TO_W      = DEF_TO_W
) (
    input  logic            CK,
    input  logic            RESET,
    input  logic            SHORT_n,
    input  logic            SLOW_n,
    input  logic            BRK_n,
    input  logic            LONG,
    input  logic            HIT,
    input  logic            DLY0_n,
    input  logic            DLY1_n,
    input  logic            CSDELAY0,
    input  logic            WAIT1,
    input  logic            WAIT2,
    input  logic            CGNTCACT_n,
    output logic            TERM_n,
    output logic [CC_W-1:0] CC_n,
    output logic [2:0]      CLS,
    output logic            TOUT
);

    // Lengths carry one extra bit so that a length of exactly 2**CC_W fits.
    localparam logic [CC_W:0]   L_SHORT = (CC_W+1)'(LEN_SHORT);
    localparam logic [CC_W:0]   L_FAST  = (CC_W+1)'(LEN_FAST);
    localparam logic [CC_W:0]   L_NORM  = (CC_W+1)'(LEN_NORM);
    localparam logic [CC_W:0]   L_SLOW  = (CC_W+1)'(LEN_SLOW);
    localparam logic [CC_W:0]   L_BRK   = (CC_W+1)'(LEN_BRK);
    localparam logic [CC_W:0]   L_LONG  = (CC_W+1)'(LEN_LONG);
    localparam logic [CC_W-1:0] POS_A   = CC_W'(WAIT_POS);
    localparam logic [CC_W-1:0] POS_B   = CC_W'(WAIT_POS + 1);
    localparam logic [CC_W-1:0] TICK1   = CC_W'(1);

    // Reject parameter sets the counter cannot represent or where a stall
    // point would coincide with (or lie past) the terminating tick.
    localparam int CC_MAX = 2 ** CC_W;
    localparam bit PARAMS_OK =
        (CC_W >= 1) && (TO_W >= 2) && (WAIT_POS >= 0) &&
        (LEN_SHORT >= 2) && (LEN_FAST >= 2) && (LEN_NORM >= 2) &&
        (LEN_SLOW >= 2) && (LEN_BRK >= 2) && (LEN_LONG >= 2) &&
        (LEN_SHORT <= CC_MAX) && (LEN_FAST + 1 <= CC_MAX) &&
        (LEN_NORM <= CC_MAX) && (LEN_SLOW <= CC_MAX) &&
        (LEN_BRK <= CC_MAX) && (LEN_LONG <= CC_MAX) &&
        (WAIT_POS + 1 < LEN_NORM) && (WAIT_POS + 1 < LEN_SLOW) &&
        (WAIT_POS + 1 < LEN_BRK) && (WAIT_POS + 1 < LEN_LONG);

    generate
        if (!PARAMS_OK) begin : g_bad_params
            $error("cyc_ctl_gen: illegal CC_W/LEN_*/WAIT_POS/TO_W combination");
        end
    endgenerate

    function automatic logic [CC_W:0] len_of(input cls_e c);
        case (c)
            CLS_SHORT: return L_SHORT;
            CLS_FAST:  return L_FAST;
            CLS_SLOW:  return L_SLOW;
            CLS_BRK:   return L_BRK;
            CLS_LONG:  return L_LONG;
            default:   return L_NORM;
        endcase
    endfunction

    logic [CC_W-1:0] cnt_q, cnt_d;
    logic [CC_W-1:0] cc_n_q, cc_n_d;
    logic [CC_W:0]   len_q, len_d;
    cls_e            cls_q, cls_d;
    logic            term_n_q, term_n_d;

    logic            last;
    logic            wait_cls;
    logic            stall_req;
    logic            hold;

    always_comb begin
        // TERM_n already marks the final tick; the next edge starts tick 0.
        last  = !term_n_q;
        cls_d = cls_q;
        len_d = len_q;

        if (cnt_q == '0) begin
            cls_d = class_sel(LONG, BRK_n, SLOW_n, SHORT_n, DLY0_n, CSDELAY0, HIT);
            len_d = len_of(cls_d);
        end

        // FAST cycles never stall, so tick 1 is seen exactly once per cycle
        // and the stretch cannot apply twice.
        if (cls_d == CLS_FAST && cnt_q == TICK1 && !DLY1_n && !last)
            len_d = len_d + 1'b1;

        wait_cls  = (cls_d == CLS_NORM) || (cls_d == CLS_SLOW) || (cls_d == CLS_LONG);
        stall_req = 1'b0;
        if (cnt_q == POS_A)
            stall_req = wait_cls ? ((WAIT1 && BRK_n) || !CGNTCACT_n)
                                 : ((cls_d == CLS_BRK) && !CGNTCACT_n);
        else if (cnt_q == POS_B)
            stall_req = wait_cls && WAIT2 && BRK_n;

        if (last)
            cnt_d = '0;
        else if (hold)
            cnt_d = cnt_q;
        else
            cnt_d = cnt_q + 1'b1;

        // TERM_n is decided one edge early so the output stays registered.
        term_n_d = last || ({1'b0, cnt_d} != (len_d - 1'b1));
        cc_n_d   = ~cnt_d;
    end

    cyc_ctl_wdog #(
        .TO_W (TO_W)
    ) u_wdog (
        .clk       (CK),
        .rst       (RESET),
        .stall_req (stall_req),
        .hold      (hold),
        .tout      (TOUT)
    );

    always_ff @(posedge CK or posedge RESET) begin
        if (RESET) begin
            cnt_q    <= '0;
            cc_n_q   <= '1;
            len_q    <= L_NORM;
            cls_q    <= CLS_NORM;
            term_n_q <= 1'b1;
        end else begin
            cnt_q    <= cnt_d;
            cc_n_q   <= cc_n_d;
            len_q    <= len_d;
            cls_q    <= cls_d;
            term_n_q <= term_n_d;
        end
    end

    assign TERM_n = term_n_q;
    assign CC_n   = cc_n_q;
    assign CLS    = cls_q;

endmodule

// File: tb/tb_cyc_ctl_gen.sv
// -----------------------------------------------------------------------------
// tb_cyc_ctl_gen
// Bench for cyc_ctl_gen with default parameters. A behavioural model tracks
// tick index, class, length and the length of the current stall, and every
// tick all four outputs are compared against it. Directed cycles with
// hand-computed lengths pin the model, followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_cyc_ctl_gen;

    logic       CK = 1'b0;
    logic       RESET = 1'b1;
    logic       SHORT_n, SLOW_n, BRK_n, LONG, HIT;
    logic       DLY0_n, DLY1_n, CSDELAY0;
    logic       WAIT1, WAIT2, CGNTCACT_n;
    logic       TERM_n;
    logic [3:0] CC_n;
    logic [2:0] CLS;
    logic       TOUT;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: current tick index, class, length, ticks already held at
    // the current stall point, and expected TOUT for the current tick.
    int m_cnt, m_cls, m_len, m_held;
    int m_tout;
    int lens[6] = '{2, 3, 4, 8, 8, 9};
    localparam int WPOS      = 2;
    localparam int MAX_STALL = 63;

    cyc_ctl_gen #(
        .CC_W(4), .LEN_SHORT(2), .LEN_FAST(3), .LEN_NORM(4), .LEN_SLOW(8),
        .LEN_BRK(8), .LEN_LONG(9), .WAIT_POS(2), .TO_W(6)
    ) dut (
        .CK(CK), .RESET(RESET), .SHORT_n(SHORT_n), .SLOW_n(SLOW_n),
        .BRK_n(BRK_n), .LONG(LONG), .HIT(HIT), .DLY0_n(DLY0_n),
        .DLY1_n(DLY1_n), .CSDELAY0(CSDELAY0), .WAIT1(WAIT1), .WAIT2(WAIT2),
        .CGNTCACT_n(CGNTCACT_n), .TERM_n(TERM_n), .CC_n(CC_n), .CLS(CLS),
        .TOUT(TOUT)
    );

    always #5 CK = ~CK;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int classify();
        if (LONG) return 5;
        if (!BRK_n) return 4;
        if (!SLOW_n) return 3;
        if (!SHORT_n && DLY0_n && !CSDELAY0) return 0;
        if (HIT || !SHORT_n) return 1;
        return 2;
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_cls = 2; m_len = 4; m_held = 0; m_tout = 0;
    endtask

    // Advance the model across one rising edge using the inputs of the tick
    // that edge ends.
    task automatic model_step();
        int  cls, len, stall_no;
        bit  want, hold, stalls;
        if (RESET) begin
            model_reset();
            return;
        end
        cls = (m_cnt == 0) ? classify() : m_cls;
        len = (m_cnt == 0) ? lens[cls] : m_len;
        if (cls == 1 && m_cnt == 1 && !DLY1_n) len = len + 1;
        stalls = (cls == 2 || cls == 3 || cls == 5);
        want = 0;
        if (m_cnt == WPOS && stalls && ((WAIT1 && BRK_n) || !CGNTCACT_n)) want = 1;
        if (m_cnt == WPOS && cls == 4 && !CGNTCACT_n) want = 1;
        if (m_cnt == WPOS + 1 && stalls && WAIT2 && BRK_n) want = 1;
        stall_no = m_held + 1;
        hold = want && (stall_no < MAX_STALL);
        m_tout = (hold && stall_no + 1 == MAX_STALL) ? 1 : 0;
        if (m_cnt == len - 1) begin
            m_cnt = 0; m_held = 0;
        end else if (hold) begin
            m_held = m_held + 1;
        end else begin
            m_cnt = m_cnt + 1; m_held = 0;
        end
        m_cls = cls;
        m_len = len;
    endtask

    task automatic compare_model();
        int exp_term;
        exp_term = (m_cnt != 0 && m_cnt == m_len - 1) ? 0 : 1;
        chk("model_cc_n", int'(CC_n), (~m_cnt) & 15);
        chk("model_term_n", int'(TERM_n), exp_term);
        chk("model_cls", int'(CLS), m_cls);
        chk("model_tout", int'(TOUT), m_tout);
    endtask

    task automatic cyc();
        @(posedge CK);
        model_step();
        @(negedge CK);
        compare_model();
    endtask

    task automatic set_idle();
        LONG = 0; BRK_n = 1; SLOW_n = 1; SHORT_n = 1; HIT = 0;
        DLY0_n = 1; DLY1_n = 1; CSDELAY0 = 0;
        WAIT1 = 0; WAIT2 = 0; CGNTCACT_n = 1;
    endtask

    // Run one whole cycle from tick 0 with a mode-specific stimulus, report
    // its length and what was seen, then step into tick 0 of the next cycle.
    task automatic run_cycle(input int mode, output int len, output int tout_cnt,
                             output int tout_k, output int cc_t, output int cls_t);
        int k;
        bit done;
        k = 0; done = 0; len = -1; tout_cnt = 0; tout_k = -1; cc_t = -1; cls_t = -1;
        while (!done && k < 200) begin
            set_idle();
            case (mode)
                0: SHORT_n = 0;
                1: begin
                    if (k == 0) HIT = 1;
                    if (k == 1) DLY1_n = 0;
                end
                2: if (k >= 2 && k <= 6) WAIT1 = 1;
                3: begin
                    BRK_n = 0;
                    if (k >= 2 && k <= 6) WAIT1 = 1;
                end
                4: CGNTCACT_n = 0;
                5: begin LONG = 1; BRK_n = 0; end
                default: ;
            endcase
            cyc();
            k++;
            if (TOUT) begin tout_cnt++; tout_k = k; end
            if (!TERM_n) begin
                done = 1; len = k + 1; cc_t = int'(CC_n); cls_t = int'(CLS);
            end
        end
        if (!done) chk("cycle_budget", 0, 1);
        set_idle();
        cyc();
    endtask

    initial begin
        int len, tc, tk, cct, clst, burst;
        model_reset();
        set_idle();
        RESET = 1;
        repeat (3) cyc();
        chk("rst_cc_n", int'(CC_n), 15);
        chk("rst_term_n", int'(TERM_n), 1);
        chk("rst_cls", int'(CLS), 2);
        chk("rst_tout", int'(TOUT), 0);
        RESET = 0;

        // SHORT held: TERM_n every second tick, CC_n alternating.
        SHORT_n = 0;
        cyc();
        chk("short_t1_cc_n", int'(CC_n), 14);
        chk("short_t1_term_n", int'(TERM_n), 0);
        chk("short_t1_cls", int'(CLS), 0);
        cyc();
        chk("short_t0_cc_n", int'(CC_n), 15);
        chk("short_t0_term_n", int'(TERM_n), 1);
        cyc();
        chk("short_t1b_term_n", int'(TERM_n), 0);
        cyc();

        run_cycle(0, len, tc, tk, cct, clst);
        chk("short_len", len, 2);
        run_cycle(1, len, tc, tk, cct, clst);
        chk("fast_dly1_len", len, 4);
        chk("fast_dly1_cc_n", cct, 12);
        chk("fast_dly1_cls", clst, 1);
        run_cycle(2, len, tc, tk, cct, clst);
        chk("norm_wait1_len", len, 9);
        chk("norm_wait1_cls", clst, 2);
        run_cycle(3, len, tc, tk, cct, clst);
        chk("brk_wait1_len", len, 8);
        chk("brk_wait1_cls", clst, 4);
        run_cycle(4, len, tc, tk, cct, clst);
        chk("wdog_len", len, 66);
        chk("wdog_tout_count", tc, 1);
        chk("wdog_tout_tick", tk, 64);
        chk("wdog_term_cc_n", cct, 12);
        run_cycle(5, len, tc, tk, cct, clst);
        chk("long_brk_len", len, 9);
        chk("long_brk_cls", clst, 5);

        // Asynchronous reset in the middle of a SLOW cycle.
        set_idle();
        SLOW_n = 0;
        cyc();
        set_idle();
        repeat (4) cyc();
        chk("slow_t5_cc_n", int'(CC_n), 10);
        #2;
        RESET = 1;
        model_reset();
        #1;
        chk("async_rst_cc_n", int'(CC_n), 15);
        chk("async_rst_term_n", int'(TERM_n), 1);
        chk("async_rst_cls", int'(CLS), 2);
        chk("async_rst_tout", int'(TOUT), 0);
        cyc();
        RESET = 0;
        SHORT_n = 0;
        cyc();
        chk("post_rst_cls", int'(CLS), 0);
        chk("post_rst_cc_n", int'(CC_n), 14);
        chk("post_rst_term_n", int'(TERM_n), 0);
        set_idle();
        cyc();

        // Randomized traffic, with occasional long bus-grant stalls.
        burst = 0;
        for (int i = 0; i < 4000; i++) begin
            LONG       = ($urandom_range(0, 7) == 0);
            BRK_n      = ($urandom_range(0, 7) != 0);
            SLOW_n     = ($urandom_range(0, 5) != 0);
            SHORT_n    = ($urandom_range(0, 2) != 0);
            HIT        = $urandom_range(0, 1);
            DLY0_n     = $urandom_range(0, 1);
            DLY1_n     = $urandom_range(0, 1);
            CSDELAY0   = ($urandom_range(0, 3) == 0);
            WAIT1      = ($urandom_range(0, 2) == 0);
            WAIT2      = ($urandom_range(0, 2) == 0);
            CGNTCACT_n = ($urandom_range(0, 7) != 0);
            if (burst == 0 && $urandom_range(0, 399) == 0)
                burst = $urandom_range(50, 90);
            if (burst > 0) begin
                CGNTCACT_n = 0;
                burst--;
            end
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
